// File: rtl/truth_table_scanner.sv
// Sweeps a combinational choice function through every input vector and
// captures its complete truth table plus a count of the 1s observed.
module truth_table_scanner #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [N_IN-1:0]       x,
    input  logic                  y,
    output logic [2**N_IN-1:0]    truth_table,
    output logic [N_IN:0]         ones
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  X_LAST   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             sample_edge;
    logic             last_vec;

    // y is sampled on the last cycle of each settle window
    assign sample_edge = (state == SCAN) && (cnt == CNT_LAST);
    assign last_vec    = (x == X_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (sample_edge && last_vec) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SCAN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            cnt         <= '0;
            truth_table <= '0;
            ones        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    x   <= '0;
                    cnt <= '0;
                    if (start) begin
                        truth_table <= '0;
                        ones        <= '0;
                    end
                end
                SCAN: begin
                    if (sample_edge) begin
                        truth_table[x] <= y;
                        ones           <= ones + {{N_IN{1'b0}}, y};
                        cnt            <= '0;
                        x              <= last_vec ? '0 : x + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    x   <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: default SETTLE=2 instance and a
// SETTLE=1 instance driven by selectable choice-function stubs.
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic        busy0, busy1, done0, done1;
    logic [4:0]  x0, x1;
    logic        y0, y1;
    logic [31:0] tbl0, tbl1;
    logic [5:0]  ones0, ones1;

    int mode;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic stub(input int m, input logic [4:0] v);
        case (m)
            0:       return v[0];
            1:       return &v;
            2:       return 1'b1;
            3:       return ($countones(v) >= 3);
            4:       return ~v[0];
            5:       return v[4];
            default: return 1'b0;
        endcase
    endfunction

    always_comb y0 = stub(mode, x0);
    always_comb y1 = stub(mode, x1);

    truth_table_scanner u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .x(x0), .y(y0), .truth_table(tbl0), .ones(ones0)
    );

    truth_table_scanner #(.N_IN(5), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .x(x1), .y(y1), .truth_table(tbl1), .ones(ones1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one scan on the selected instance; poke_x >= 0 pulses start while x equals it.
    task automatic scan(input bit sel, input int poke_x, input string tag,
                        input int exp_cyc, input logic [31:0] exp_tbl, input logic [5:0] exp_ones);
        int cyc, bcnt, xbad, settle;
        bit poked;
        logic [31:0] tbl_acc;
        logic [5:0]  ones_acc;
        logic        b, d;
        logic [4:0]  xs;
        settle = sel ? 1 : 2;
        poked = 1'b0;
        xbad = 0;
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        tbl_acc  = sel ? tbl1 : tbl0;
        ones_acc = sel ? ones1 : ones0;
        b  = sel ? busy1 : busy0;
        xs = sel ? x1 : x0;
        bcnt = b ? 1 : 0;
        if (xs !== 5'd0) xbad++;
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            b  = sel ? busy1 : busy0;
            d  = sel ? done1 : done0;
            xs = sel ? x1 : x0;
            if (d) break;
            if (b) begin
                bcnt++;
                if (int'(xs) != cyc / settle) xbad++;
            end
            if (poke_x >= 0 && !poked && int'(xs) == poke_x) begin
                poked = 1'b1;
                if (sel) start1 = 1'b1; else start0 = 1'b1;
            end
        end
        check({tag, "_cleared_at_accept"}, {26'd0, ones_acc, tbl_acc}, 64'd0);
        check({tag, "_done_latency"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_cyc));
        check({tag, "_x_trajectory"}, 64'(xbad), 64'd0);
        check({tag, "_table"}, 64'(sel ? tbl1 : tbl0), 64'(exp_tbl));
        check({tag, "_ones"}, 64'(sel ? ones1 : ones0), 64'(exp_ones));
        check({tag, "_x_after_done"}, 64'(xs), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(sel ? done1 : done0), 64'd0);
    endtask

    initial begin
        logic [31:0] maj_tbl;
        int          maj_ones;
        int          guard;
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode = 0;
        #1;
        check("reset_state", {busy0, done0, x0, tbl0, ones0}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        mode = 0;
        scan(1'b0, -1, "y_x0", 64, 32'hAAAAAAAA, 6'd16);

        mode = 1;
        scan(1'b0, -1, "y_and", 64, 32'h80000000, 6'd1);

        mode = 2;
        scan(1'b0, -1, "y_one", 64, 32'hFFFFFFFF, 6'b100000);

        mode = 3;
        maj_tbl = '0;
        maj_ones = 0;
        for (int i = 0; i < 32; i++) begin
            maj_tbl[i] = ($countones(5'(i)) >= 3);
            if (maj_tbl[i]) maj_ones++;
        end
        check("maj_model_ones", 64'(maj_ones), 64'd16);
        scan(1'b0, -1, "y_maj", 64, maj_tbl, 6'(maj_ones));
        for (int i = 0; i < 32; i++) begin
            if (tbl0[i] !== maj_tbl[i]) begin
                check($sformatf("maj_bit%0d", i), 64'(tbl0[i]), 64'(maj_tbl[i]));
            end
        end

        // Asynchronous reset mid-scan at x=10
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        guard = 0;
        while (x0 !== 5'd10 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reached_x10", 64'(x0), 64'd10);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {busy0, done0, x0, tbl0, ones0}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {busy0, done0, x0, tbl0, ones0}, 64'd0);

        mode = 0;
        scan(1'b0, 5, "start_ignored", 64, 32'hAAAAAAAA, 6'd16);

        mode = 4;
        scan(1'b0, -1, "y_notx0", 64, 32'h55555555, 6'd16);

        mode = 5;
        scan(1'b1, -1, "settle1", 32, 32'hFFFF0000, 6'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
